if_fetch_unit: RTL and testbench

Instruction-fetch control stage wrapped around the PC register. Drives `next_pc` and `pc_en` into the PC register and issues instruction-memory requests at the current `pc`. Buffers in-order responses with their PCs in a small FIFO toward decode. Handles branch/jump redirects by flushing buffered instructions and discarding stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch control around the PC register: issues in-order fetches under a
// credit limit, buffers {instr, pc} toward decode and squashes stale work on redirect.
module if_fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;
    logic [31:0]   tag_mem   [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          run;
    logic          redirect;
    logic          issue;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          pop;
    logic [CW:0]   credits_used;

    // Every fetch holds a credit from issue until decode pops it, so the FIFO cannot overflow.
    assign run            = (state == RUN);
    assign credits_used   = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = run && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid && imem_req_ready;
    assign redirect       = run && redirect_valid;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep       = rsp_fire && (drop == '0) && !redirect;
    assign if_valid       = (count != '0);
    assign if_instr       = instr_mem[fifo_rd];
    assign if_pc          = pc_mem[fifo_rd];
    assign pop            = if_valid && if_ready;

    always_comb begin
        next_pc = pc;
        pc_en   = 1'b0;
        if (redirect) begin
            next_pc = redirect_pc & 32'hFFFF_FFFC;
            pc_en   = 1'b1;
        end else if (issue) begin
            next_pc = pc + 32'd4;
            pc_en   = 1'b1;
        end
    end

    // A redirect turns every still-pending response into one to discard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (state == IDLE) begin
                state <= RUN;
            end
            if (redirect) begin
                outstanding <= outstanding - CW'(rsp_fire);
                drop        <= outstanding - CW'(rsp_fire);
            end else begin
                outstanding <= outstanding + CW'(issue) - CW'(rsp_fire);
                if (rsp_fire && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (redirect) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (issue) begin
                tag_mem[tag_wr] <= pc;
                tag_wr          <= tag_wr + PW'(1);
            end
            if (rsp_keep) begin
                tag_rd <= tag_rd + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_wr <= '0;
            fifo_rd <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect) begin
            fifo_wr <= '0;
            fifo_rd <= '0;
            count   <= '0;
        end else begin
            if (rsp_keep) begin
                instr_mem[fifo_wr] <= imem_rsp_data;
                pc_mem[fifo_wr]    <= tag_mem[tag_rd];
                fifo_wr            <= fifo_wr + PW'(1);
            end
            if (pop) begin
                fifo_rd <= fifo_rd + PW'(1);
            end
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order memory and PC register models plus a
// queue-based reference of fetch credits, stale responses and the decode FIFO.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] pc_init = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= pc_init;
        else if (pc_en) pc <= next_pc;
    end

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; } tag_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t  fifo_q[$];
    tag_t  outq[$];
    mreq_t mem_q[$];
    ent_t  dut_log[$];
    bit          m_run;
    logic [31:0] m_pc;
    int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    bit force_rsp = 0;

    bit          s_redir, s_ifr, s_rsp, s_mem_rsp, s_dut_fire, s_dut_pop;
    logic [31:0] s_rpc, s_data, s_addr;
    ent_t        s_dut_ent;
    bit          e_req_valid, e_fire, e_pc_en, e_if_valid;
    logic [31:0] e_next_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    // Drive one cycle's inputs at the falling edge and derive the expected outputs.
    task automatic drive(input bit redir, input logic [31:0] rpc, input bit rdy, input bit ifr);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if_ready       = ifr;
        s_mem_rsp      = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = s_mem_rsp || force_rsp;
        imem_rsp_data  = s_mem_rsp ? mem_data(mem_q[0].addr) : $urandom;
        #1;
        s_redir    = redir;
        s_rpc      = rpc;
        s_ifr      = ifr;
        s_rsp      = imem_rsp_valid;
        s_data     = imem_rsp_data;
        s_dut_fire = imem_req_valid && imem_req_ready;
        s_addr     = imem_req_addr;
        s_dut_pop  = if_valid && if_ready;
        s_dut_ent.instr = if_instr;
        s_dut_ent.pc    = if_pc;
        e_req_valid = m_run && !redir && (fifo_q.size() + outq.size() < DEPTH);
        e_fire      = e_req_valid && rdy;
        e_pc_en     = (m_run && redir) || e_fire;
        e_next_pc   = (m_run && redir) ? (rpc & 32'hFFFF_FFFC) : (e_fire ? m_pc + 32'd4 : m_pc);
        e_if_valid  = (fifo_q.size() > 0);
    endtask

    task automatic advance();
        tag_t t;
        ent_t e;
        mreq_t r;
        int d;
        @(posedge clk);
        if (s_mem_rsp) void'(mem_q.pop_front());
        if (s_dut_fire) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.addr = s_addr;
            r.due  = d;
            mem_q.push_back(r);
        end
        if (s_dut_pop) dut_log.push_back(s_dut_ent);
        if (m_run) begin
            if (s_ifr && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (s_redir) fifo_q.delete();
            if (s_rsp && outq.size() > 0) begin
                t = outq.pop_front();
                if (!t.stale && !s_redir) begin
                    e.instr = s_data;
                    e.pc    = t.pc;
                    fifo_q.push_back(e);
                end
            end
            if (s_redir) begin
                for (int i = 0; i < outq.size(); i++) begin
                    t = outq[i];
                    t.stale = 1'b1;
                    outq[i] = t;
                end
            end
            if (e_fire) begin
                t.pc = m_pc;
                t.stale = 1'b0;
                outq.push_back(t);
            end
            if (s_redir) m_pc = s_rpc & 32'hFFFF_FFFC;
            else if (e_fire) m_pc = m_pc + 32'd4;
        end else if (reset) begin
            m_run = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] init, input int ncyc);
        pc_init = init;
        reset   = 1'b0;
        m_run   = 1'b0;
        m_pc    = init;
        fifo_q.delete();
        outq.delete();
        mem_q.delete();
        dut_log.delete();
        force_rsp = 1'b0;
        last_due  = cyc;
        repeat (ncyc) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_reset();
        do_reset(32'h0, 1);
        force_rsp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
            checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_pc_en got=%b exp=0", pc_en); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_if_valid got=%b exp=0", if_valid); end
            advance();
        end
        checks++; if (next_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_next_pc got=%h exp=0", next_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_if_instr got=%h exp=0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_if_pc got=%h exp=0", if_pc); end
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_req_valid got=%b exp=0", imem_req_valid); end
        advance();
        force_rsp = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_req_valid got=%b exp=1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req_addr got=%h exp=0", imem_req_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL spurious_rsp got=%b exp=0", if_valid); end
        advance();
    endtask

    task automatic test_streaming();
        int nfire = 0;
        lat_min = 1; lat_max = 1;
        do_reset(32'h0, 3);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            checks++; if (imem_req_valid !== e_req_valid) begin errors++; $display("[TB] FAIL stream_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, e_req_valid); end
            if (s_dut_fire) begin
                checks++; if (s_addr !== 32'(nfire * 4)) begin errors++; $display("[TB] FAIL stream_addr got=%h exp=%h", s_addr, 32'(nfire * 4)); end
                nfire++;
            end
            advance();
        end
        checks++; if (dut_log.size() < 10) begin errors++; $display("[TB] FAIL stream_count got=%0d exp>=10", dut_log.size()); end
        for (int i = 0; i < dut_log.size(); i++) begin
            checks++; if (dut_log[i].pc !== 32'(i * 4) || dut_log[i].instr !== mem_data(32'(i * 4))) begin
                errors++; $display("[TB] FAIL stream_decode idx=%0d got=%h/%h exp=%h/%h", i, dut_log[i].pc, dut_log[i].instr, 32'(i * 4), mem_data(32'(i * 4)));
            end
        end
    endtask

    task automatic test_backpressure();
        int nfire = 0;
        logic [31:0] resume_addr = 32'hDEAD_BEEF;
        bit seen = 0;
        lat_min = 1; lat_max = 1;
        do_reset(32'h0, 3);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            if (s_dut_fire) nfire++;
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (nfire != 2) begin errors++; $display("[TB] FAIL bp_fires got=%0d exp=2", nfire); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_pc_en got=%b exp=0", pc_en); end
        checks++; if (pc !== 32'h8) begin errors++; $display("[TB] FAIL bp_pc_hold got=%h exp=8", pc); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head got=%b/%h exp=1/0", if_valid, if_pc); end
        advance();
        dut_log.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            if (s_dut_fire && !seen) begin seen = 1; resume_addr = s_addr; end
            advance();
        end
        checks++; if (dut_log.size() < 2 || dut_log[0].pc !== 32'h0 || dut_log[1].pc !== 32'h4) begin
            errors++; $display("[TB] FAIL bp_drain got_n=%0d exp first pcs 0,4", dut_log.size());
        end
        checks++; if (resume_addr !== 32'h8) begin errors++; $display("[TB] FAIL bp_resume got=%h exp=8", resume_addr); end
    endtask

    task automatic test_redirect_inflight();
        int nfire = 0;
        int n = 0;
        lat_min = 3; lat_max = 3;
        do_reset(32'h0, 3);
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        advance();
        while (nfire < 2 && n < 10) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            if (s_dut_fire) nfire++;
            advance();
            n++;
        end
        checks++; if (nfire != 2) begin errors++; $display("[TB] FAIL rdi_setup got=%0d exp=2", nfire); end
        dut_log.delete();
        drive(1'b1, 32'h100, 1'b1, 1'b1);
        checks++; if (next_pc !== 32'h100 || pc_en !== 1'b1) begin errors++; $display("[TB] FAIL rdi_next_pc got=%h/%b exp=100/1", next_pc, pc_en); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdi_req_block got=%b exp=0", imem_req_valid); end
        advance();
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (pc !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdi_after got=%h/%b exp=100/0", pc, if_valid); end
        advance();
        n = 0;
        while (dut_log.size() == 0 && n < 20) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            advance();
            n++;
        end
        checks++;
        if (dut_log.size() == 0) begin
            errors++; $display("[TB] FAIL rdi_timeout got=none exp=pc 100");
        end else if (dut_log[0].pc !== 32'h100 || dut_log[0].instr !== mem_data(32'h100)) begin
            errors++; $display("[TB] FAIL rdi_first got=%h/%h exp=100/%h", dut_log[0].pc, dut_log[0].instr, mem_data(32'h100));
        end
    endtask

    task automatic test_redirect_rsp();
        bit found = 0;
        int n = 0;
        lat_min = 2; lat_max = 2;
        do_reset(32'h0, 3);
        reset = 1'b1;
        while (!found && n < 12) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && if_valid) begin
                found = 1;
                drive(1'b1, 32'h300, 1'b1, 1'b0);
                advance();
                drive(1'b0, '0, 1'b1, 1'b0);
                checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdr_flush got=%b exp=0", if_valid); end
                checks++; if (pc !== 32'h300) begin errors++; $display("[TB] FAIL rdr_pc got=%h exp=300", pc); end
                advance();
            end else begin
                drive(1'b0, '0, 1'b1, 1'b0);
                advance();
            end
            n++;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL rdr_setup got=no coincident response exp=one"); end
        dut_log.delete();
        n = 0;
        while (dut_log.size() == 0 && n < 20) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            advance();
            n++;
        end
        checks++; if (dut_log.size() == 0 || dut_log[0].pc !== 32'h300) begin
            errors++; $display("[TB] FAIL rdr_first got_n=%0d exp first pc 300", dut_log.size());
        end
    endtask

    task automatic test_misaligned_wrap();
        lat_min = 1; lat_max = 1;
        do_reset(32'h0, 3);
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        advance();
        drive(1'b1, 32'h203, 1'b1, 1'b1);
        checks++; if (next_pc !== 32'h200 || pc_en !== 1'b1) begin errors++; $display("[TB] FAIL mis_next_pc got=%h/%b exp=200/1", next_pc, pc_en); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (pc !== 32'h200 || imem_req_addr !== 32'h200) begin errors++; $display("[TB] FAIL mis_pc got=%h/%h exp=200", pc, imem_req_addr); end
        advance();
        do_reset(32'hFFFF_FFFC, 3);
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        advance();
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr); end
        checks++; if (next_pc !== 32'h0 || pc_en !== 1'b1) begin errors++; $display("[TB] FAIL wrap_next_pc got=%h/%b exp=0/1", next_pc, pc_en); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got=%h exp=0", pc); end
        advance();
    endtask

    task automatic test_async_reset();
        bit found = 0;
        lat_min = 1; lat_max = 1;
        do_reset(32'h0, 3);
        reset = 1'b1;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            if (imem_req_valid && if_valid && pc_en) found = 1;
            else advance();
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL arst_setup got=not all active exp=active"); end
        #1 reset = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_if_valid got=%b exp=0", if_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL arst_pc_en got=%b exp=0", pc_en); end
        @(negedge clk);
        do_reset(32'h0, 2);
        reset = 1'b1;
    endtask

    task automatic test_random();
        bit redir, rdy, ifr;
        logic [31:0] rpc;
        lat_min = 1; lat_max = 3;
        do_reset(32'h0, 3);
        reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            redir = ($urandom_range(99, 0) < 8);
            rpc   = $urandom;
            rdy   = ($urandom_range(3, 0) != 0);
            ifr   = ($urandom_range(3, 0) != 0);
            drive(redir, rpc, rdy, ifr);
            checks++; if (imem_req_valid !== e_req_valid) begin errors++; $display("[TB] FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, e_req_valid); end
            checks++; if (pc_en !== e_pc_en) begin errors++; $display("[TB] FAIL rnd_pc_en cyc=%0d got=%b exp=%b", cyc, pc_en, e_pc_en); end
            checks++; if (next_pc !== e_next_pc) begin errors++; $display("[TB] FAIL rnd_next_pc cyc=%0d got=%h exp=%h", cyc, next_pc, e_next_pc); end
            checks++; if (pc !== m_pc || imem_req_addr !== m_pc) begin errors++; $display("[TB] FAIL rnd_pc cyc=%0d got=%h/%h exp=%h", cyc, pc, imem_req_addr, m_pc); end
            checks++; if (if_valid !== e_if_valid) begin errors++; $display("[TB] FAIL rnd_if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, e_if_valid); end
            if (e_if_valid) begin
                checks++; if (if_pc !== fifo_q[0].pc || if_instr !== fifo_q[0].instr) begin
                    errors++; $display("[TB] FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", cyc, if_pc, if_instr, fifo_q[0].pc, fifo_q[0].instr);
                end
            end
            advance();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_rsp();
        test_misaligned_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=still running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
